// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: a DEPTH-entry circular buffer
// of {instr, pc, pc+4}, head presented from storage, cleared on an execute redirect.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Valid_F,
  output logic                     Ready_F,
  input  logic [31:0]              PC_F,
  input  logic [31:0]              PCPlus4_F,
  input  logic [31:0]              Instr_F,
  input  logic                     Flush_E,
  input  logic                     Stall_D,
  output logic                     Valid_D,
  output logic [31:0]              Instr_D,
  output logic [31:0]              PC_D,
  output logic [31:0]              PCPlus4_D,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0]   NOP  = 32'h0000_0013;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          head_vld;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] pc4_mem   [DEPTH];

  // DEPTH is a power of two, so natural overflow of the pointer is the wrap.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + 1'b1;
  endfunction

  // Ready never looks at a same-cycle pop: a full queue refuses fetch outright.
  assign head_vld = (count != '0);
  assign Ready_F  = (count < FULL) && !Flush_E;
  assign push     = Valid_F && Ready_F;
  assign pop      = head_vld && !Stall_D && !Flush_E;

  // Control state: pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (Flush_E) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; contents only matter below count.
  always_ff @(posedge clk) begin
    if (push && rst) begin
      instr_mem[wr_ptr] <= Instr_F;
      pc_mem[wr_ptr]    <= PC_F;
      pc4_mem[wr_ptr]   <= PCPlus4_F;
    end
  end

  // Decode-side head, forced to NOP/0 when nothing is queued
  always_comb begin
    Valid_D   = head_vld;
    Instr_D   = NOP;
    PC_D      = '0;
    PCPlus4_D = '0;
    if (head_vld) begin
      Instr_D   = instr_mem[rd_ptr];
      PC_D      = pc_mem[rd_ptr];
      PCPlus4_D = pc4_mem[rd_ptr];
    end
  end

  assign Count = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a hand-derived vector table for the directed corners,
// then randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_F;
  logic        Ready_F;
  logic [31:0] PC_F;
  logic [31:0] PCPlus4_F;
  logic [31:0] Instr_F;
  logic        Flush_E;
  logic        Stall_D;
  logic        Valid_D;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PCPlus4_D;
  logic [$clog2(DEPTH):0] Count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .Valid_F(Valid_F), .Ready_F(Ready_F),
    .PC_F(PC_F), .PCPlus4_F(PCPlus4_F), .Instr_F(Instr_F),
    .Flush_E(Flush_E), .Stall_D(Stall_D),
    .Valid_D(Valid_D), .Instr_D(Instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .Count(Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, v, f, s;
    logic [31:0] pc;
    logic        chk_rdy;
    logic        exp_rdy;
    logic        exp_vld;
    logic [31:0] exp_pc;
    int          exp_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] instr, pc, pc4;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc ^ 32'h5A5A_0000) + 32'h0000_0033;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, v, input logic [31:0] pc, input logic f, s,
                     input logic cr, er, ev, input logic [31:0] epc, input int ecnt);
    vec_t t;
    t.r = r; t.v = v; t.pc = pc; t.f = f; t.s = s;
    t.chk_rdy = cr; t.exp_rdy = er; t.exp_vld = ev; t.exp_pc = epc; t.exp_cnt = ecnt;
    vecs.push_back(t);
  endtask

  // Drive inputs, check Ready_F before the edge, then move to just after the edge.
  task automatic drive(input logic r, v, f, s, input logic [31:0] pc, instr,
                       input logic chk_rdy, input logic exp_rdy, input string tag);
    rst = r; Valid_F = v; Flush_E = f; Stall_D = s;
    PC_F = pc; PCPlus4_F = pc + 32'd4; Instr_F = instr;
    #1;
    if (chk_rdy) check({tag, " Ready_F"}, 32'(Ready_F), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic ev, input logic [31:0] einstr,
                            input logic [31:0] epc, input logic [31:0] epc4, input int ecnt);
    check({tag, " Valid_D"},   32'(Valid_D), 32'(ev));
    check({tag, " Instr_D"},   Instr_D,   einstr);
    check({tag, " PC_D"},      PC_D,      epc);
    check({tag, " PCPlus4_D"}, PCPlus4_D, epc4);
    check({tag, " Count"},     32'(Count), 32'(ecnt));
  endtask

  initial begin
    rst = 1'b0; Valid_F = 1'b0; Flush_E = 1'b0; Stall_D = 1'b0;
    PC_F = '0; PCPlus4_F = 32'd4; Instr_F = '0;

    //  r  v  pc      f  s   chkR expR  vld  pc      cnt
    // reset, then idle
    add(0, 0, 32'h0,  0, 0,  0,   0,    0,   32'h0,  0);
    add(0, 0, 32'h0,  0, 0,  1,   1,    0,   32'h0,  0);
    add(1, 0, 32'h0,  0, 0,  1,   1,    0,   32'h0,  0);
    // streaming: head lags fetch by one, count holds at 1
    add(1, 1, 32'h0,  0, 0,  1,   1,    1,   32'h0,  1);
    add(1, 1, 32'h4,  0, 0,  1,   1,    1,   32'h4,  1);
    add(1, 1, 32'h8,  0, 0,  1,   1,    1,   32'h8,  1);
    add(1, 0, 32'h0,  0, 0,  1,   1,    0,   32'h0,  0);
    // fill under stall, 5th refused, then drain in order
    add(1, 1, 32'h0,  0, 1,  1,   1,    1,   32'h0,  1);
    add(1, 1, 32'h4,  0, 1,  1,   1,    1,   32'h0,  2);
    add(1, 1, 32'h8,  0, 1,  1,   1,    1,   32'h0,  3);
    add(1, 1, 32'hC,  0, 1,  1,   1,    1,   32'h0,  4);
    add(1, 1, 32'h10, 0, 1,  1,   0,    1,   32'h0,  4);
    add(1, 1, 32'h10, 0, 0,  1,   0,    1,   32'h4,  3);
    add(1, 1, 32'h10, 0, 0,  1,   1,    1,   32'h8,  3);
    add(1, 0, 32'h0,  0, 0,  1,   1,    1,   32'hC,  2);
    add(1, 0, 32'h0,  0, 0,  1,   1,    1,   32'h10, 1);
    add(1, 0, 32'h0,  0, 0,  1,   1,    0,   32'h0,  0);
    // flush with a concurrent push: nothing survives
    add(1, 1, 32'h20, 0, 1,  1,   1,    1,   32'h20, 1);
    add(1, 1, 32'h24, 0, 1,  1,   1,    1,   32'h20, 2);
    add(1, 1, 32'h28, 0, 1,  1,   1,    1,   32'h20, 3);
    add(1, 1, 32'h40, 1, 0,  1,   0,    0,   32'h0,  0);
    add(1, 1, 32'h80, 0, 1,  1,   1,    1,   32'h80, 1);
    add(1, 0, 32'h0,  0, 0,  1,   1,    0,   32'h0,  0);
    // reset mid-run drops queued and in-flight entries
    add(1, 1, 32'h100,0, 1,  1,   1,    1,   32'h100,1);
    add(1, 1, 32'h104,0, 1,  1,   1,    1,   32'h100,2);
    add(0, 1, 32'h108,0, 1,  1,   1,    0,   32'h0,  0);
    add(1, 1, 32'h10C,0, 1,  1,   1,    1,   32'h10C,1);
    add(1, 0, 32'h0,  0, 0,  1,   1,    0,   32'h0,  0);
    // stall on an empty queue
    add(1, 0, 32'h0,  0, 1,  1,   1,    0,   32'h0,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      drive(vecs[i].r, vecs[i].v, vecs[i].f, vecs[i].s, vecs[i].pc, instr_of(vecs[i].pc),
            vecs[i].chk_rdy, vecs[i].exp_rdy, tag);
      check_head(tag, vecs[i].exp_vld,
                 vecs[i].exp_vld ? instr_of(vecs[i].exp_pc) : NOP,
                 vecs[i].exp_pc,
                 vecs[i].exp_vld ? vecs[i].exp_pc + 32'd4 : 32'h0,
                 vecs[i].exp_cnt);
    end

    // Randomized traffic against a queue model; the table leaves the DUT empty.
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      logic r, v, f, s, exp_rdy, head_vld, pushed;
      logic [31:0] pc, instr;
      ent_t e;
      string tag;
      r     = ($urandom_range(0, 79) != 0);
      v     = ($urandom_range(0, 2) != 0);
      f     = ($urandom_range(0, 19) == 0);
      s     = ($urandom_range(0, 2) == 0);
      pc    = $urandom & 32'hFFFF_FFFC;
      instr = $urandom;
      tag   = $sformatf("rand%0d", c);

      exp_rdy  = (mq.size() < DEPTH) && !f;
      head_vld = (mq.size() != 0);
      drive(r, v, f, s, pc, instr, 1'b1, exp_rdy, tag);

      if (!r || f) begin
        mq.delete();
      end else begin
        pushed = v && exp_rdy;
        if (head_vld && !s) void'(mq.pop_front());
        if (pushed) begin
          e.instr = instr; e.pc = pc; e.pc4 = pc + 32'd4;
          mq.push_back(e);
        end
      end

      if (mq.size() != 0)
        check_head(tag, 1'b1, mq[0].instr, mq[0].pc, mq[0].pc4, mq.size());
      else
        check_head(tag, 1'b0, NOP, 32'h0, 32'h0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the fetch stage and decode. It buffers up to DEPTH fetched instructions with their PCs, so a decode stall does not throw away fetch work. It presents the oldest entry to decode and discards everything on a control-flow redirect from execute. All storage is clocked; the decode-side outputs are driven from queue storage, with no same-cycle bypass from the fetch inputs.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the next rising edge)
- Valid_F  in  1  fetch presents a valid instruction this cycle
- Ready_F  out  1  queue can accept an entry this cycle
- PC_F  in  32  PC of the presented instruction
- PCPlus4_F  in  32  PC_F+4 from fetch
- Instr_F  in  32  fetched instruction word
- Flush_E  in  1  taken redirect from execute (PCSrc_E≠0); discard all entries
- Stall_D  in  1  decode holds; head entry is not consumed
- Valid_D  out  1  head entry valid
- Instr_D  out  32  head instruction; 32'h00000013 (NOP) when Valid_D=0
- PC_D  out  32  head PC; 0 when Valid_D=0
- PCPlus4_D  out  32  head PC+4; 0 when Valid_D=0
- Count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

## Operation
- Circular buffer with wr_ptr, rd_ptr (each $clog2(DEPTH) bits, wrap modulo DEPTH) and a count register.
- Ready_F = (Count < DEPTH) && !Flush_E.
- push = Valid_F && Ready_F: write {Instr_F, PC_F, PCPlus4_F} at wr_ptr; wr_ptr+1.
- pop = Valid_D && !Stall_D && !Flush_E: rd_ptr+1.
- Count_next = Count + push − pop. Simultaneous push and pop leaves Count unchanged.
- Full (Count=DEPTH): Ready_F=0 even when a pop occurs the same cycle. There is no pass-through when full.
- Empty (Count=0): Valid_D=0, and the outputs show NOP/0. A push into an empty queue becomes visible on the outputs the next cycle.
- Valid_D = (Count≠0). The head fields are mem[rd_ptr], muxed to the NOP/0 values when Valid_D=0.
- Flush_E=1: on the next edge wr_ptr=rd_ptr=0 and Count=0. Any same-cycle push or pop is suppressed. Storage contents are don't-care.
- Flush_E has priority over Stall_D and Valid_F. rst has priority over everything.
- Stall_D with an empty queue has no effect. Valid_F=0 produces no write.
- The fetch side must hold PC when Ready_F=0. This block does not drive PC stall; the hazard logic uses !Ready_F.

## Timing
- Reset (rst=0 at an edge): Count=0, pointers=0, Valid_D=0, Instr_D=32'h00000013, PC_D=0, PCPlus4_D=0, Ready_F=1 (when Flush_E=0).
- Latency: an entry pushed at edge N appears at the head after edge N if the queue was empty. Otherwise it appears after all older entries have popped.
- Throughput: one push and one pop per cycle sustained, with Count constant.
- Flush at edge N: Valid_D=0 from edge N. The first post-redirect instruction, pushed at edge N+1, is valid after N+1.
- Reset asserted mid-operation clears state at that edge. Any in-flight push is lost.
- No combinational path from Valid_F/Instr_F to the decode-side outputs. Ready_F depends combinationally only on Count and Flush_E.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then rst=1 with Valid_F=0 → Valid_D=0, Instr_D=0x00000013, Count=0, Ready_F=1.
- Streaming: push PC 0,4,8,… with Stall_D=0 → Valid_D high from cycle 2, PC_D lags PC_F by 1 cycle, Count stays 1, and PCPlus4_D=PC_D+4.
- Fill and stall: Stall_D=1 while pushing 5 instructions (DEPTH=4) → Count reaches 4 and Ready_F=0 on the 5th. Releasing the stall yields PCs 0,4,8,12 in order, and the 5th is accepted once Count<4.
- Wrap-around: 10 pushes and pops with stalls interleaved so the pointers wrap twice → output order equals input order and Count never exceeds 4.
- Flush: Count=3, then Flush_E=1 together with Valid_F=1 (PC 0x40) → after the edge Count=0, Valid_D=0, and PC 0x40 is not stored. A push of PC 0x80 next cycle appears as PC_D=0x80.
- Reset mid-run: Count=2, then rst=0 for one edge → Count=0 and outputs at NOP/0. After rst=1, the next push appears unchanged.
